// File: rtl/vga_fb_scanner.sv
// VGA scan engine: pixel-rate enable, timing counters, framebuffer address
// generation one pixel period ahead, and aligned RGB/sync/blank to the DAC.
`timescale 1ns/1ps
module vga_fb_scanner #(
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter int          CLK_DIV     = 2,
  parameter int          SCALE_SHIFT = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] datain,
  output logic [31:0] dir,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_sync,
  output logic        o_blank,
  output logic        o_clk,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_HALF   = DW'(CLK_DIV / 2);
  localparam logic [31:0]   LINE_WORDS = 32'(H_ACTIVE >> SCALE_SHIFT);

  if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_bad_clk_div
    $error("vga_fb_scanner: CLK_DIV must be even and >= 2");
  end
  if ((H_ACTIVE % (1 << SCALE_SHIFT)) != 0) begin : g_bad_scale
    $error("vga_fb_scanner: H_ACTIVE must be divisible by 2**SCALE_SHIFT");
  end

  logic [DW-1:0] d;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          active_d, hsync_n_d, vsync_n_d;

  logic [DW-1:0] d_next;
  logic          tick, h_wrap, v_wrap;
  logic          active, hsync_n, vsync_n;
  logic [31:0]   fetch_addr;
  logic [7:0]    unused_hi;

  assign unused_hi = datain[31:24];
  assign o_sync    = 1'b0;

  assign tick    = (d == D_LAST);
  assign d_next  = tick ? '0 : d + DW'(1);
  assign h_wrap  = (hcount == H_LAST);
  assign v_wrap  = (vcount == V_LAST);
  assign active  = (hcount < H_ACT) && (vcount < V_ACT);
  assign hsync_n = !((hcount >= HS_START) && (hcount <= HS_END));
  assign vsync_n = !((vcount >= VS_START) && (vcount <= VS_END));

  // Counter position is the fetch stage; the display stage consumes the
  // word one pixel period later, so both pipelines stay in lockstep.
  assign fetch_addr = active
      ? BASE_ADDR + ((32'(vcount) >> SCALE_SHIFT) * LINE_WORDS) + (32'(hcount) >> SCALE_SHIFT)
      : BASE_ADDR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= '0; hcount <= '0; vcount <= '0;
      active_d <= 1'b0; hsync_n_d <= 1'b1; vsync_n_d <= 1'b1;
      dir <= BASE_ADDR; r <= '0; g <= '0; b <= '0;
      o_hs <= 1'b1; o_vs <= 1'b1; o_blank <= 1'b0; o_clk <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      d <= '0; hcount <= '0; vcount <= '0;
      active_d <= 1'b0; hsync_n_d <= 1'b1; vsync_n_d <= 1'b1;
      dir <= BASE_ADDR; r <= '0; g <= '0; b <= '0;
      o_hs <= 1'b1; o_vs <= 1'b1; o_blank <= 1'b0; o_clk <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      d           <= d_next;
      o_clk       <= (d_next >= D_HALF);
      // The reset already parks the counters at (0,0), so only a wrap pulses.
      frame_start <= tick && h_wrap && v_wrap;
      if (tick) begin
        hcount <= h_wrap ? '0 : hcount + HW'(1);
        if (h_wrap) vcount <= v_wrap ? '0 : vcount + VW'(1);
        dir       <= fetch_addr;
        active_d  <= active;
        hsync_n_d <= hsync_n;
        vsync_n_d <= vsync_n;
        r       <= active_d ? datain[23:16] : 8'h00;
        g       <= active_d ? datain[15:8]  : 8'h00;
        b       <= active_d ? datain[7:0]   : 8'h00;
        o_blank <= active_d;
        o_hs    <= hsync_n_d;
        o_vs    <= vsync_n_d;
      end
    end
  end

endmodule
